capture_segment_ctrl: RTL and testbench
=======================================

Name: capture_segment_ctrl

Overview:
- Downstream of the ADC trigger unit.
- Consumes its per-segment start pulse (capture_go) and produces sample write-enables for the sample FIFO.
- Counts samples per segment and segments per capture, and returns capture_done to the trigger unit when the capture completes or aborts.
- Supports two segment modes: per-trigger (each segment waits for a go pulse) and timed (segments follow the first at a fixed cycle pitch).

Parameters:
- SAMP_W, 32, width of sample counters and num_samples_i.
- SEG_W, 16, width of segment counters and num_segments_i.
- CYC_W, 20, width of segment_cycles_i and the pitch counter.

Ports:
- adc_clk  in  1  ADC sample clock.
- reset  in  1  asynchronous, active-high reset.
- arm_i  in  1  capture arm level; rising edge starts a capture, low aborts it.
- capture_go_i  in  1  one-cycle segment start pulse from the trigger unit.
- num_samples_i  in  SAMP_W  samples per segment; 0 is treated as 1.
- num_segments_i  in  SEG_W  segments per capture; 0 is treated as 1.
- segment_cycles_i  in  CYC_W  0 = per-trigger mode; nonzero = timed mode pitch in cycles, measured start-to-start.
- fifo_full_i  in  1  sample FIFO full.
- sample_wr_o  out  1  FIFO write enable, one sample per cycle.
- segment_first_o  out  1  high with the first sample_wr_o of each segment.
- capture_done_o  out  1  level; high from completion/abort until arm_i low.
- segment_count_o  out  SEG_W  segments completed in this capture.
- sample_count_o  out  SAMP_W  samples written in the current segment.
- overflow_o  out  1  sticky FIFO overflow flag.
- state_o  out  3  FSM state, for debug.

Behaviour:
- Reset (async): state IDLE; all outputs 0; internal arm_dly 0; pitch counter 0.
- All outputs registered. Config inputs are sampled on the arm rising edge and held for the capture.
- State encodings: IDLE=0, WAIT_GO=1, CAPTURE=2, WAIT_NEXT=3, DONE=4.
- IDLE:
  - arm_i & ~arm_dly -> WAIT_GO.
  - Clears segment_count_o, sample_count_o and overflow_o.
- WAIT_GO: capture_go_i -> CAPTURE. Pitch counter loads 1.
- Write latency: go sampled at edge N -> sample_wr_o high for cycles N+1 .. N+S, where S = max(num_samples,1).
- CAPTURE, every cycle:
  - sample_wr_o = 1.
  - segment_first_o = 1 only on the first cycle.
  - sample_count_o increments; it reads k after k writes.
  - The pitch counter increments.
- On the last sample (count == S-1):
  - segment_count_o increments.
  - If new segment_count == max(num_segments,1) -> DONE.
  - Else if per-trigger mode -> WAIT_NEXT.
  - Else if pitch counter >= segment_cycles_i -> CAPTURE again (back-to-back); sample_count_o restarts, segment_first_o = 1, pitch counter = 1.
  - Else -> WAIT_NEXT.
- WAIT_NEXT, per-trigger mode: capture_go_i -> CAPTURE, with the same latency as WAIT_GO.
- WAIT_NEXT, timed mode: the pitch counter increments; when it equals segment_cycles_i -> CAPTURE. Consecutive segment starts are exactly segment_cycles_i cycles apart.
- capture_go_i in CAPTURE, DONE or timed-mode WAIT_NEXT is ignored.
- DONE: capture_done_o = 1 and sample_wr_o = 0. Stays here until arm_i = 0 -> IDLE; capture_done_o falls on the following edge.
- Abort (arm_i = 0 in WAIT_GO, CAPTURE or WAIT_NEXT):
  - Next cycle: IDLE, sample_wr_o 0, capture_done_o stays 0.
  - Counters hold their values.
- Overflow (fifo_full_i = 1 while sample_wr_o = 1):
  - Set overflow_o.
  - Next cycle: DONE, sample_wr_o 0, capture_done_o 1.
  - The segment in progress is not counted.
- Simultaneous events:
  - Abort beats overflow and last-sample.
  - Overflow beats last-sample.
- A new arm rising edge while in DONE is impossible, because arm_i must fall first.
- Counters saturate: no wrap past all-ones.

Test Plan:
- Per-trigger single segment: S=5, segs=1, arm then go at edge 10 -> sample_wr_o on cycles 11..15; segment_first_o at 11 only; capture_done_o=1 from 16; segment_count_o=1.
- Per-trigger multi-segment: S=3, segs=3, go pulses at 10, 20, 30 -> three 3-cycle bursts starting at 11, 21, 31; go at 12 ignored; done after the third burst; segment_count_o=3.
- Timed mode: S=4, segs=3, segment_cycles=10, go at 5 -> bursts at 6, 16, 26; done at 30. Then segment_cycles=2 (≤S) -> 12 contiguous writes with segment_first_o at 6, 10, 14.
- Zero config: S=0, segs=0 -> exactly one write, then done.
- Overflow: S=8, fifo_full_i high on the 4th write -> overflow_o=1; sample_wr_o low next cycle; capture_done_o=1; segment_count_o=0. overflow_o clears on the next arm rising edge.
- Abort/reset: arm_i low mid-burst -> sample_wr_o 0 next cycle, capture_done_o never asserts. Async reset mid-CAPTURE -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/capture_segment_ctrl.sv
// -----------------------------------------------------------------------------
// capture_segment_ctrl
//
// Purpose:
//   Sits downstream of the ADC trigger unit. Turns per-segment start pulses
//   into sample-FIFO write enables, counts samples per segment and segments
//   per capture, and reports capture completion (or FIFO overflow) back to
//   the trigger unit. Two segment modes:
//     - per-trigger : every segment waits for its own capture_go_i pulse
//     - timed       : segments after the first start segment_cycles_i cycles
//                     apart (start-to-start), measured by a pitch counter
//
// Ports:
//   adc_clk           ADC sample clock
//   reset             asynchronous, active-high reset
//   arm_i             arm level: rising edge starts a capture, low aborts it
//   capture_go_i      one-cycle segment start pulse from the trigger unit
//   num_samples_i     samples per segment (0 treated as 1)
//   num_segments_i    segments per capture (0 treated as 1)
//   segment_cycles_i  0 = per-trigger mode, else timed-mode pitch in cycles
//   fifo_full_i       sample FIFO full
//   sample_wr_o       FIFO write enable, one sample per cycle
//   segment_first_o   marks the first write of each segment
//   capture_done_o    high from completion/overflow until arm_i drops
//   segment_count_o   segments completed in this capture
//   sample_count_o    samples written in the current segment
//   overflow_o        sticky FIFO overflow flag
//   state_o           FSM state (debug)
// -----------------------------------------------------------------------------
module capture_segment_ctrl #(
    parameter int SAMP_W = 32,
    parameter int SEG_W  = 16,
    parameter int CYC_W  = 20
) (
    input  logic              adc_clk,
    input  logic              reset,
    input  logic              arm_i,
    input  logic              capture_go_i,
    input  logic [SAMP_W-1:0] num_samples_i,
    input  logic [SEG_W-1:0]  num_segments_i,
    input  logic [CYC_W-1:0]  segment_cycles_i,
    input  logic              fifo_full_i,
    output logic              sample_wr_o,
    output logic              segment_first_o,
    output logic              capture_done_o,
    output logic [SEG_W-1:0]  segment_count_o,
    output logic [SAMP_W-1:0] sample_count_o,
    output logic              overflow_o,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_GO   = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_WAIT_NEXT = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // Saturating increments: counters stick at all-ones instead of wrapping.
    function automatic logic [SAMP_W-1:0] sat_inc_samp(input logic [SAMP_W-1:0] v);
        if (v == {SAMP_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(SAMP_W-1){1'b0}}, 1'b1};
        end
    endfunction

    function automatic logic [SEG_W-1:0] sat_inc_seg(input logic [SEG_W-1:0] v);
        if (v == {SEG_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(SEG_W-1){1'b0}}, 1'b1};
        end
    endfunction

    function automatic logic [CYC_W-1:0] sat_inc_cyc(input logic [CYC_W-1:0] v);
        if (v == {CYC_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CYC_W-1){1'b0}}, 1'b1};
        end
    endfunction

    localparam logic [SAMP_W-1:0] SAMP_ONE = {{(SAMP_W-1){1'b0}}, 1'b1};
    localparam logic [SEG_W-1:0]  SEG_ONE  = {{(SEG_W-1){1'b0}}, 1'b1};
    localparam logic [CYC_W-1:0]  CYC_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};

    state_t            state_q,     state_d;
    logic              arm_dly_q;
    logic [SAMP_W-1:0] nsamp_q,     nsamp_d;
    logic [SEG_W-1:0]  nseg_q,      nseg_d;
    logic [CYC_W-1:0]  cyc_q,       cyc_d;
    logic [CYC_W-1:0]  pitch_q,     pitch_d;
    logic [SEG_W-1:0]  seg_cnt_q,   seg_cnt_d;
    logic [SAMP_W-1:0] samp_cnt_q,  samp_cnt_d;
    logic              ovf_q,       ovf_d;
    logic              wr_q,        wr_d;
    logic              first_q,     first_d;
    logic              done_q,      done_d;

    logic              arm_rise_s;
    logic              last_s;
    logic              timed_s;
    logic [SEG_W-1:0]  seg_next_s;

    assign arm_rise_s = arm_i & ~arm_dly_q;
    // nsamp_q is never 0 (zero is promoted to 1 when latched), so S-1 is safe.
    assign last_s     = (samp_cnt_q == (nsamp_q - SAMP_ONE));
    assign timed_s    = (cyc_q != {CYC_W{1'b0}});
    assign seg_next_s = sat_inc_seg(seg_cnt_q);

    // Next-state and next-output logic for the capture FSM.
    always_comb begin
        state_d    = state_q;
        nsamp_d    = nsamp_q;
        nseg_d     = nseg_q;
        cyc_d      = cyc_q;
        pitch_d    = pitch_q;
        seg_cnt_d  = seg_cnt_q;
        samp_cnt_d = samp_cnt_q;
        ovf_d      = ovf_q;
        first_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Counters and overflow survive in IDLE so an aborted or
                // overflowed capture can be inspected; they clear on re-arm.
                if (arm_rise_s) begin
                    state_d    = ST_WAIT_GO;
                    nsamp_d    = (num_samples_i == {SAMP_W{1'b0}}) ? SAMP_ONE : num_samples_i;
                    nseg_d     = (num_segments_i == {SEG_W{1'b0}}) ? SEG_ONE : num_segments_i;
                    cyc_d      = segment_cycles_i;
                    pitch_d    = {CYC_W{1'b0}};
                    seg_cnt_d  = {SEG_W{1'b0}};
                    samp_cnt_d = {SAMP_W{1'b0}};
                    ovf_d      = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT_GO: begin
                if (!arm_i) begin
                    state_d = ST_IDLE;
                end else if (capture_go_i) begin
                    state_d    = ST_CAPTURE;
                    first_d    = 1'b1;
                    pitch_d    = CYC_ONE;
                    samp_cnt_d = {SAMP_W{1'b0}};
                end else begin
                    state_d = ST_WAIT_GO;
                end
            end

            ST_CAPTURE: begin
                // Priority: abort > overflow > last sample.
                if (!arm_i) begin
                    state_d = ST_IDLE;
                end else if (fifo_full_i) begin
                    // Rejected write: segment in progress is not counted.
                    ovf_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    samp_cnt_d = sat_inc_samp(samp_cnt_q);
                    pitch_d    = sat_inc_cyc(pitch_q);
                    if (last_s) begin
                        seg_cnt_d = seg_next_s;
                        if (seg_next_s == nseg_q) begin
                            state_d = ST_DONE;
                        end else if (!timed_s) begin
                            state_d = ST_WAIT_NEXT;
                        end else if (pitch_q >= cyc_q) begin
                            // Pitch already elapsed: next segment starts
                            // back-to-back with this one.
                            state_d    = ST_CAPTURE;
                            first_d    = 1'b1;
                            samp_cnt_d = {SAMP_W{1'b0}};
                            pitch_d    = CYC_ONE;
                        end else begin
                            state_d = ST_WAIT_NEXT;
                        end
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end
            end

            ST_WAIT_NEXT: begin
                if (!arm_i) begin
                    state_d = ST_IDLE;
                end else if (timed_s) begin
                    // pitch_q counts 1 on the first write cycle of the
                    // previous segment, so reaching cyc_q here places the
                    // next first write exactly cyc_q cycles after it.
                    if (pitch_q >= cyc_q) begin
                        state_d    = ST_CAPTURE;
                        first_d    = 1'b1;
                        samp_cnt_d = {SAMP_W{1'b0}};
                        pitch_d    = CYC_ONE;
                    end else begin
                        pitch_d = sat_inc_cyc(pitch_q);
                    end
                end else if (capture_go_i) begin
                    state_d    = ST_CAPTURE;
                    first_d    = 1'b1;
                    samp_cnt_d = {SAMP_W{1'b0}};
                    pitch_d    = CYC_ONE;
                end else begin
                    state_d = ST_WAIT_NEXT;
                end
            end

            ST_DONE: begin
                if (!arm_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are registered from the next state so they line up with
        // the cycle the FSM spends in that state.
        wr_d   = (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
    end

    // State, configuration, counters and registered outputs.
    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            arm_dly_q  <= 1'b0;
            nsamp_q    <= SAMP_ONE;
            nseg_q     <= SEG_ONE;
            cyc_q      <= {CYC_W{1'b0}};
            pitch_q    <= {CYC_W{1'b0}};
            seg_cnt_q  <= {SEG_W{1'b0}};
            samp_cnt_q <= {SAMP_W{1'b0}};
            ovf_q      <= 1'b0;
            wr_q       <= 1'b0;
            first_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            arm_dly_q  <= arm_i;
            nsamp_q    <= nsamp_d;
            nseg_q     <= nseg_d;
            cyc_q      <= cyc_d;
            pitch_q    <= pitch_d;
            seg_cnt_q  <= seg_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            ovf_q      <= ovf_d;
            wr_q       <= wr_d;
            first_q    <= first_d;
            done_q     <= done_d;
        end
    end

    assign sample_wr_o     = wr_q;
    assign segment_first_o = first_q;
    assign capture_done_o  = done_q;
    assign segment_count_o = seg_cnt_q;
    assign sample_count_o  = samp_cnt_q;
    assign overflow_o      = ovf_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_capture_segment_ctrl.sv
// -----------------------------------------------------------------------------
// tb_capture_segment_ctrl
//
// Directed test of capture_segment_ctrl: per-trigger single and multi segment,
// timed mode with a wide and a back-to-back pitch, zero configuration,
// FIFO overflow, arm abort and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_capture_segment_ctrl;

    localparam int SAMP_W = 32;
    localparam int SEG_W  = 16;
    localparam int CYC_W  = 20;

    logic              adc_clk;
    logic              reset;
    logic              arm_i;
    logic              capture_go_i;
    logic [SAMP_W-1:0] num_samples_i;
    logic [SEG_W-1:0]  num_segments_i;
    logic [CYC_W-1:0]  segment_cycles_i;
    logic              fifo_full_i;
    logic              sample_wr_o;
    logic              segment_first_o;
    logic              capture_done_o;
    logic [SEG_W-1:0]  segment_count_o;
    logic [SAMP_W-1:0] sample_count_o;
    logic              overflow_o;
    logic [2:0]        state_o;

    int n_assert;
    int n_fail;

    capture_segment_ctrl #(
        .SAMP_W (SAMP_W),
        .SEG_W  (SEG_W),
        .CYC_W  (CYC_W)
    ) dut (
        .adc_clk          (adc_clk),
        .reset            (reset),
        .arm_i            (arm_i),
        .capture_go_i     (capture_go_i),
        .num_samples_i    (num_samples_i),
        .num_segments_i   (num_segments_i),
        .segment_cycles_i (segment_cycles_i),
        .fifo_full_i      (fifo_full_i),
        .sample_wr_o      (sample_wr_o),
        .segment_first_o  (segment_first_o),
        .capture_done_o   (capture_done_o),
        .segment_count_o  (segment_count_o),
        .sample_count_o   (sample_count_o),
        .overflow_o       (overflow_o),
        .state_o          (state_o)
    );

    initial begin
        adc_clk = 1'b0;
        forever #5 adc_clk = ~adc_clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: wait for the active edge, then sample 1 time unit later.
    task automatic step();
        @(posedge adc_clk);
        #1;
    endtask

    initial begin
        n_assert         = 0;
        n_fail           = 0;
        reset            = 1'b1;
        arm_i            = 1'b0;
        capture_go_i     = 1'b0;
        num_samples_i    = 32'd0;
        num_segments_i   = 16'd0;
        segment_cycles_i = 20'd0;
        fifo_full_i      = 1'b0;

        // ---------------- reset state
        #12;
        chk("rst_wr",    64'(sample_wr_o),     64'd0);
        chk("rst_first", 64'(segment_first_o), 64'd0);
        chk("rst_done",  64'(capture_done_o),  64'd0);
        chk("rst_seg",   64'(segment_count_o), 64'd0);
        chk("rst_samp",  64'(sample_count_o),  64'd0);
        chk("rst_ovf",   64'(overflow_o),      64'd0);
        chk("rst_state", 64'(state_o),         64'd0);
        reset = 1'b0;
        step();

        // ---------------- per-trigger single segment, S=5
        num_samples_i    = 32'd5;
        num_segments_i   = 16'd1;
        segment_cycles_i = 20'd0;
        arm_i = 1'b1;
        step();
        chk("t1_waitgo", 64'(state_o), 64'd1);
        step();
        chk("t1_idle_wr", 64'(sample_wr_o), 64'd0);
        capture_go_i = 1'b1;
        step();
        capture_go_i = 1'b0;
        chk("t1_wr0",    64'(sample_wr_o),     64'd1);
        chk("t1_first0", 64'(segment_first_o), 64'd1);
        chk("t1_state",  64'(state_o),         64'd2);
        for (int k = 1; k < 5; k++) begin
            step();
            chk("t1_wr",    64'(sample_wr_o),     64'd1);
            chk("t1_first", 64'(segment_first_o), 64'd0);
            chk("t1_samp",  64'(sample_count_o),  64'(k));
        end
        step();
        chk("t1_wr_end", 64'(sample_wr_o),     64'd0);
        chk("t1_done",   64'(capture_done_o),  64'd1);
        chk("t1_seg",    64'(segment_count_o), 64'd1);
        chk("t1_samp5",  64'(sample_count_o),  64'd5);
        chk("t1_sdone",  64'(state_o),         64'd4);
        step();
        chk("t1_done_hold", 64'(capture_done_o), 64'd1);
        arm_i = 1'b0;
        step();
        chk("t1_done_fall", 64'(capture_done_o), 64'd0);
        chk("t1_idle",      64'(state_o),        64'd0);

        // ---------------- per-trigger multi segment, S=3, 3 segments
        num_samples_i  = 32'd3;
        num_segments_i = 16'd3;
        arm_i = 1'b1;
        step();
        for (int s = 0; s < 3; s++) begin
            step();
            chk("t2_gap_wr", 64'(sample_wr_o), 64'd0);
            capture_go_i = 1'b1;
            step();
            capture_go_i = 1'b0;
            chk("t2_wr1",    64'(sample_wr_o),     64'd1);
            chk("t2_first1", 64'(segment_first_o), 64'd1);
            step();
            chk("t2_wr2",    64'(sample_wr_o),     64'd1);
            chk("t2_first2", 64'(segment_first_o), 64'd0);
            // go pulse during a burst must be ignored
            capture_go_i = 1'b1;
            step();
            capture_go_i = 1'b0;
            chk("t2_wr3",    64'(sample_wr_o),     64'd1);
            chk("t2_first3", 64'(segment_first_o), 64'd0);
            step();
            chk("t2_wr_off", 64'(sample_wr_o),     64'd0);
            chk("t2_seg",    64'(segment_count_o), 64'(s + 1));
            if (s < 2) begin
                chk("t2_waitnext", 64'(state_o),        64'd3);
                chk("t2_notdone",  64'(capture_done_o), 64'd0);
            end else begin
                chk("t2_done", 64'(capture_done_o), 64'd1);
            end
        end
        arm_i = 1'b0;
        step();

        // ---------------- timed mode, S=4, 3 segments, pitch 10
        num_samples_i    = 32'd4;
        num_segments_i   = 16'd3;
        segment_cycles_i = 20'd10;
        arm_i = 1'b1;
        step();
        capture_go_i = 1'b1;
        step();
        capture_go_i = 1'b0;
        for (int t = 0; t <= 24; t++) begin
            chk("t3_wr",    64'(sample_wr_o),     64'((t % 10) < 4 && t < 24));
            chk("t3_first", 64'(segment_first_o), 64'((t % 10) == 0 && t < 24));
            chk("t3_done",  64'(capture_done_o),  64'(t == 24));
            if (t < 24) begin
                // stray go while waiting out the pitch must be ignored
                capture_go_i = (t == 6);
                step();
                capture_go_i = 1'b0;
            end
        end
        chk("t3_seg", 64'(segment_count_o), 64'd3);
        arm_i = 1'b0;
        step();

        // ---------------- timed mode, pitch 2 <= S: back-to-back segments
        segment_cycles_i = 20'd2;
        arm_i = 1'b1;
        step();
        capture_go_i = 1'b1;
        step();
        capture_go_i = 1'b0;
        for (int t = 0; t <= 12; t++) begin
            chk("t4_wr",    64'(sample_wr_o),     64'(t < 12));
            chk("t4_first", 64'(segment_first_o), 64'((t % 4) == 0 && t < 12));
            chk("t4_done",  64'(capture_done_o),  64'(t == 12));
            if (t < 12) begin
                step();
            end
        end
        arm_i = 1'b0;
        step();

        // ---------------- zero configuration: one write then done
        num_samples_i    = 32'd0;
        num_segments_i   = 16'd0;
        segment_cycles_i = 20'd0;
        arm_i = 1'b1;
        step();
        capture_go_i = 1'b1;
        step();
        capture_go_i = 1'b0;
        chk("t5_wr",    64'(sample_wr_o),     64'd1);
        chk("t5_first", 64'(segment_first_o), 64'd1);
        step();
        chk("t5_wr_off", 64'(sample_wr_o),     64'd0);
        chk("t5_done",   64'(capture_done_o),  64'd1);
        chk("t5_seg",    64'(segment_count_o), 64'd1);
        arm_i = 1'b0;
        step();

        // ---------------- overflow on the 4th write, S=8
        num_samples_i  = 32'd8;
        num_segments_i = 16'd1;
        arm_i = 1'b1;
        step();
        capture_go_i = 1'b1;
        step();
        capture_go_i = 1'b0;
        step();
        step();
        step();
        chk("t6_wr4", 64'(sample_wr_o), 64'd1);
        fifo_full_i = 1'b1;
        step();
        fifo_full_i = 1'b0;
        chk("t6_ovf",   64'(overflow_o),      64'd1);
        chk("t6_wr",    64'(sample_wr_o),     64'd0);
        chk("t6_done",  64'(capture_done_o),  64'd1);
        chk("t6_seg",   64'(segment_count_o), 64'd0);
        chk("t6_state", 64'(state_o),         64'd4);
        arm_i = 1'b0;
        step();
        chk("t6_ovf_sticky", 64'(overflow_o), 64'd1);
        arm_i = 1'b1;
        step();
        chk("t6_ovf_clr", 64'(overflow_o), 64'd0);
        chk("t6_rearm",   64'(state_o),    64'd1);

        // ---------------- abort mid-burst (armed above with S=8)
        capture_go_i = 1'b1;
        step();
        capture_go_i = 1'b0;
        step();
        chk("t7_wr2", 64'(sample_wr_o), 64'd1);
        arm_i = 1'b0;
        step();
        chk("t7_wr_off", 64'(sample_wr_o),    64'd0);
        chk("t7_idle",   64'(state_o),        64'd0);
        chk("t7_nodone", 64'(capture_done_o), 64'd0);
        chk("t7_hold",   64'(sample_count_o), 64'd1);
        step();
        step();
        chk("t7_nodone2", 64'(capture_done_o), 64'd0);

        // ---------------- async reset mid-capture
        arm_i = 1'b1;
        step();
        capture_go_i = 1'b1;
        step();
        capture_go_i = 1'b0;
        step();
        chk("t8_wr_pre", 64'(sample_wr_o), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t8_wr",    64'(sample_wr_o),     64'd0);
        chk("t8_first", 64'(segment_first_o), 64'd0);
        chk("t8_done",  64'(capture_done_o),  64'd0);
        chk("t8_seg",   64'(segment_count_o), 64'd0);
        chk("t8_samp",  64'(sample_count_o),  64'd0);
        chk("t8_ovf",   64'(overflow_o),      64'd0);
        chk("t8_state", 64'(state_o),         64'd0);
        #2;
        arm_i = 1'b0;
        reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
